// File: rtl/pixel_packer_pkg.sv
// rtl/pixel_packer_pkg.sv - shared types and beat geometry helpers for the Mono8 pixel packer
package pixel_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int calc_lanes(input int data_width, input int pixel_width);
        return data_width / pixel_width;
    endfunction

    function automatic int calc_beats(input int frame_pixels, input int lanes);
        return (frame_pixels + lanes - 1) / lanes;
    endfunction

    function automatic int calc_tail(input int frame_pixels, input int lanes);
        return frame_pixels % lanes;
    endfunction

    // Geometry of the default 256-bit / 8-bit / 48x48 configuration.
    localparam int          LANES     = calc_lanes(256, 8);
    localparam int          BEATS     = calc_beats(2304, LANES);
    localparam int          TAIL      = calc_tail(2304, LANES);
    localparam logic [31:0] KEEP_TAIL = (TAIL == 0) ? 32'hFFFF_FFFF : 32'((64'd1 << TAIL) - 64'd1);

endpackage

// File: rtl/axis_beat_reg.sv
// rtl/axis_beat_reg.sv - single-entry output holding register for one packed beat
module axis_beat_reg #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_WIDTH-1:0]   load_tdata,
    input  logic [DATA_WIDTH/8-1:0] load_tkeep,
    input  logic                    load_tlast,
    input  logic                    tready,
    output logic                    tvalid,
    output logic [DATA_WIDTH-1:0]   tdata,
    output logic [DATA_WIDTH/8-1:0] tkeep,
    output logic                    tlast
);

    // Hold the beat until it handshakes; the parent only loads when empty or draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_tdata;
            tkeep  <= load_tkeep;
            tlast  <= load_tlast;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer_mono8.sv
// rtl/pixel_packer_mono8.sv - packs a byte-wide sample stream into framed wide beats
module pixel_packer_mono8
    import pixel_packer_pkg::*;
#(
    parameter int                         PIXEL_BIT_WIDTH = 8,
    parameter int                         DATA_WIDTH      = 256,
    parameter int                         FRAME_PIXELS    = 2304,
    parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE       = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_idle,
    output logic                       ap_done,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                       m_axis_tlast
);

    localparam int N_LANES    = calc_lanes(DATA_WIDTH, PIXEL_BIT_WIDTH);
    localparam int N_TAIL     = calc_tail(FRAME_PIXELS, N_LANES);
    localparam int KEEP_W     = DATA_WIDTH / 8;
    localparam int TAIL_BYTES = N_TAIL * PIXEL_BIT_WIDTH / 8;
    localparam int LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int PIX_W      = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);

    state_t                 state, state_nxt;
    logic [LANE_W-1:0]      lane_cnt;
    logic [PIX_W-1:0]       pix_cnt;
    logic [DATA_WIDTH-1:0]  acc, merged, xfer_src, beat_data;
    logic [KEEP_W-1:0]      beat_keep;
    logic                   acc_full, acc_last;
    logic                   s_hs, at_last_lane, at_last_pix, completing;
    logic                   can_load, load, xfer_last;

    assign ap_idle = (state == IDLE);
    assign ap_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Handshakes, accumulator merge and the beat offered to the output register.
    // A beat completed by this cycle's sample may bypass the accumulator straight
    // into the output register; a beat that cannot move waits in the accumulator.
    always_comb begin
        can_load      = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = (state == RUN) && !(acc_full && !can_load);
        s_hs          = s_axis_tvalid && s_axis_tready;
        at_last_lane  = (lane_cnt == LAST_LANE);
        at_last_pix   = (pix_cnt == LAST_PIX);
        completing    = s_hs && (at_last_lane || at_last_pix);
        load          = can_load && (acc_full || completing);
        merged        = acc;
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_cnt == LANE_W'(i)) begin
                merged[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = s_axis_tdata;
            end
        end
        xfer_src  = acc_full ? acc : merged;
        xfer_last = acc_full ? acc_last : at_last_pix;
        beat_data = xfer_src;
        beat_keep = '1;
        if (xfer_last && N_TAIL != 0) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (i >= N_TAIL) begin
                    beat_data[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] = PAD_VALUE;
                end
            end
            for (int i = 0; i < KEEP_W; i++) begin
                beat_keep[i] = (i < TAIL_BYTES);
            end
        end
    end

    // Frame sequencing: arm on ap_start, collect the frame, drain the tlast beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = RUN;
            RUN:     if (s_hs && at_last_pix) state_nxt = FLUSH;
            FLUSH:   if (ap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and accumulator occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lane_cnt <= '0;
            pix_cnt  <= '0;
            acc      <= '0;
            acc_full <= 1'b0;
            acc_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ap_start) begin
                lane_cnt <= '0;
                pix_cnt  <= '0;
                acc_full <= 1'b0;
                acc_last <= 1'b0;
            end else begin
                if (s_hs) begin
                    acc      <= merged;
                    lane_cnt <= completing ? '0 : lane_cnt + 1'b1;
                    pix_cnt  <= at_last_pix ? '0 : pix_cnt + 1'b1;
                end
                if (completing) begin
                    acc_last <= at_last_pix;
                end
                // A stored beat leaving while the next one completes keeps the flag set.
                if (acc_full) begin
                    acc_full <= !load || completing;
                end else begin
                    acc_full <= completing && !can_load;
                end
            end
        end
    end

    axis_beat_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_tdata (beat_data),
        .load_tkeep (beat_keep),
        .load_tlast (xfer_last),
        .tready     (m_axis_tready),
        .tvalid     (m_axis_tvalid),
        .tdata      (m_axis_tdata),
        .tkeep      (m_axis_tkeep),
        .tlast      (m_axis_tlast)
    );

endmodule

// File: tb/tb_pixel_packer_mono8.sv
// tb/tb_pixel_packer_mono8.sv - self-checking bench for pixel_packer_mono8
module tb_pixel_packer_mono8;

    localparam int PW  = 8;
    localparam int DW  = 256;
    localparam int KW  = DW / 8;
    localparam int LN  = DW / PW;
    localparam int FA  = 2304;
    localparam int BA  = 72;
    localparam int FB  = 40;
    localparam int TMO = 20000;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic start;
        logic svalid;
        logic idle;
        logic sready;
        logic mvalid;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic          a_start = 1'b0, a_svalid = 1'b0, a_mready = 1'b1;
    logic [PW-1:0] a_sdata = '0;
    logic          a_idle, a_done, a_sready, a_mvalid, a_mlast;
    logic [DW-1:0] a_mdata;
    logic [KW-1:0] a_mkeep;

    logic          b_start = 1'b0, b_svalid = 1'b0, b_mready = 1'b1;
    logic [PW-1:0] b_sdata = '0;
    logic          b_idle, b_done, b_sready, b_mvalid, b_mlast;
    logic [DW-1:0] b_mdata;
    logic [KW-1:0] b_mkeep;

    beat_t      exp_a[$];
    beat_t      obs_a[$];
    beat_t      obs_b[$];
    logic [7:0] smp[$];
    int         done_a = 0, done_t_a = 0, done_b = 0;
    bit         rand_rdy = 1'b0;
    bit         held_a = 1'b0;
    beat_t      held_beat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_packer_mono8 dut_a (
        .clk(clk), .reset(reset), .ap_start(a_start), .ap_idle(a_idle), .ap_done(a_done),
        .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready), .s_axis_tdata(a_sdata),
        .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready), .m_axis_tdata(a_mdata),
        .m_axis_tkeep(a_mkeep), .m_axis_tlast(a_mlast)
    );

    pixel_packer_mono8 #(.FRAME_PIXELS(FB), .PAD_VALUE(8'hAA)) dut_b (
        .clk(clk), .reset(reset), .ap_start(b_start), .ap_idle(b_idle), .ap_done(b_done),
        .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata),
        .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
        .m_axis_tkeep(b_mkeep), .m_axis_tlast(b_mlast)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: beat b holds samples b*LN .. b*LN+LN-1, padding past the frame end.
    function automatic beat_t model_beat(input logic [7:0] s[$], input int frame,
                                         input logic [7:0] pad, input int b);
        beat_t r;
        int    idx;
        r.data = '0;
        r.keep = '0;
        for (int l = 0; l < LN; l++) begin
            idx = b * LN + l;
            if (idx < frame) begin
                r.data[l*PW +: PW] = s[idx];
                r.keep[l] = 1'b1;
            end else begin
                r.data[l*PW +: PW] = pad;
            end
        end
        r.last = ((b + 1) * LN >= frame);
        return r;
    endfunction

    task automatic load_frame_a(input bit rnd, input int nbeats);
        smp.delete();
        for (int i = 0; i < FA; i++) smp.push_back(rnd ? 8'($urandom) : 8'(i % 256));
        for (int b = 0; b < nbeats; b++) exp_a.push_back(model_beat(smp, FA, 8'h00, b));
    endtask

    task automatic start_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic send_a(input int stop_at, input bit gaps, output int stalls);
        int   i = 0;
        int   n = 0;
        logic hs;
        stalls = 0;
        while (i < stop_at && n < TMO) begin
            a_svalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_sdata  = a_svalid ? smp[i] : 8'($urandom);
            @(negedge clk);
            hs = a_svalid && a_sready;
            if (a_svalid && !a_sready) stalls++;
            @(posedge clk); #1;
            if (hs) i++;
            n++;
        end
        a_svalid = 1'b0;
        if (n >= TMO) begin
            checks++; errors++;
            $display("FAIL send_a_timeout: got %0d samples required %0d", i, stop_at);
        end
    endtask

    task automatic wait_idle_a(input string name);
        int n = 0;
        @(negedge clk);
        while (!(a_idle && exp_a.size() == 0) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= TMO) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats pending required 0", name, exp_a.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; a_start = 1'b0; a_svalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_window_idle", a_idle, 1);
            check("rst_window_mvalid", a_mvalid, 0);
            check("rst_window_sready", a_sready, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Random downstream backpressure for dut_a.
    always @(posedge clk) begin
        #1;
        a_mready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard and stall-stability checks for dut_a.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur.data = a_mdata; cur.keep = a_mkeep; cur.last = a_mlast;
        if (reset) begin
            held_a = 1'b0;
        end else begin
            if (held_a) begin
                check("a_stall_tvalid", a_mvalid, 1);
                check("a_stall_tdata", cur.data, held_beat.data);
                check("a_stall_tkeep", cur.keep, held_beat.keep);
                check("a_stall_tlast", cur.last, held_beat.last);
            end
            if (a_mvalid && a_mready) begin
                obs_a.push_back(cur);
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_beat: got tdata 0x%0h required no beat", cur.data);
                end else begin
                    e = exp_a.pop_front();
                    check("a_tdata", cur.data, e.data);
                    check("a_tkeep", cur.keep, e.keep);
                    check("a_tlast", cur.last, e.last);
                    check("a_ap_done", a_done, e.last);
                end
            end else if (a_done) begin
                checks++; errors++;
                $display("FAIL a_ap_done_no_handshake: got 1 required 0");
            end
            if (a_done) begin
                done_a++;
                done_t_a = cyc;
            end
            held_a    = a_mvalid && !a_mready;
            held_beat = cur;
        end
    end

    // Collector for dut_b.
    always @(negedge clk) begin
        beat_t cur;
        cur.data = b_mdata; cur.keep = b_mkeep; cur.last = b_mlast;
        if (!reset && b_mvalid && b_mready) begin
            obs_b.push_back(cur);
            check("b_ap_done", b_done, cur.last);
        end
        if (!reset && b_done) done_b++;
    end

    initial begin
        vec_t       vt[5];
        logic [7:0] bs[$];
        beat_t      eb;
        int         stalls, dc, t0, i, n;
        logic       hs;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_ap_idle", a_idle, 1);
        check("rst_ap_done", a_done, 0);
        check("rst_s_tready", a_sready, 0);
        check("rst_m_tvalid", a_mvalid, 0);
        check("rst_m_tlast", a_mlast, 0);
        check("rst_m_tkeep", a_mkeep, 0);
        check("rst_m_tdata", a_mdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Control vectors on the 40-sample instance: ap_start only honoured in IDLE.
        vt[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        b_sdata = 8'd1;
        for (int k = 0; k < 5; k++) begin
            b_start = vt[k].start; b_svalid = vt[k].svalid;
            @(negedge clk);
            check($sformatf("vec%0d_idle", k), b_idle, vt[k].idle);
            check($sformatf("vec%0d_s_tready", k), b_sready, vt[k].sready);
            check($sformatf("vec%0d_m_tvalid", k), b_mvalid, vt[k].mvalid);
            @(posedge clk); #1;
        end
        b_start = 1'b0;

        // Short frame with tail padding: samples 1..40.
        for (int k = 0; k < FB; k++) bs.push_back(8'(k + 1));
        i = 0; n = 0;
        while (i < FB && n < 1000) begin
            b_svalid = 1'b1;
            b_sdata  = bs[i];
            @(negedge clk);
            hs = b_svalid && b_sready;
            @(posedge clk); #1;
            if (hs) i++;
            n++;
        end
        b_svalid = 1'b0;
        n = 0;
        while (!b_idle && n < 100) begin @(posedge clk); #1; n++; end
        check("b_beat_count", obs_b.size(), 2);
        check("b_done_count", done_b, 1);
        if (obs_b.size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                eb = model_beat(bs, FB, 8'hAA, k);
                check($sformatf("b_beat%0d_tdata", k), obs_b[k].data, eb.data);
                check($sformatf("b_beat%0d_tkeep", k), obs_b[k].keep, eb.keep);
                check($sformatf("b_beat%0d_tlast", k), obs_b[k].last, eb.last);
            end
            check("b_beat1_lanes0_7", obs_b[1].data[63:0], 64'h2827262524232221);
            check("b_beat1_pad", obs_b[1].data[255:64], {24{8'hAA}});
            check("b_beat1_tkeep_const", obs_b[1].keep, 32'h0000_00FF);
        end

        // Full frame, 0..255 repeating, no backpressure, sustained throughput.
        load_frame_a(1'b0, BA);
        dc = done_a; obs_a.delete();
        start_a();
        t0 = cyc;
        send_a(FA, 1'b0, stalls);
        wait_idle_a("t1");
        check("t1_beat_count", obs_a.size(), BA);
        check("t1_done_count", done_a - dc, 1);
        check("t1_input_stalls", stalls, 0);
        check("t1_frame_cycles_ok", (done_t_a - t0 >= FA) && (done_t_a - t0 <= FA + 4), 1);
        if (obs_a.size() == BA) begin
            check("t1_beat0_lane0", obs_a[0].data[7:0], 8'h00);
            check("t1_beat0_lane31", obs_a[0].data[255:248], 8'h1F);
            check("t1_beat70_tlast", obs_a[70].last, 0);
            check("t1_beat71_tlast", obs_a[71].last, 1);
            check("t1_beat71_tkeep", obs_a[71].keep, 32'hFFFF_FFFF);
        end

        // Same data with random input gaps and random output backpressure.
        rand_rdy = 1'b1;
        load_frame_a(1'b0, BA);
        dc = done_a; obs_a.delete();
        start_a();
        send_a(FA, 1'b1, stalls);
        wait_idle_a("t3");
        check("t3_beat_count", obs_a.size(), BA);
        check("t3_done_count", done_a - dc, 1);
        rand_rdy = 1'b0;

        // Reset after 100 samples: only the three complete beats may appear.
        load_frame_a(1'b1, 3);
        start_a();
        send_a(100, 1'b0, stalls);
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        check("t5_complete_beats_drained", exp_a.size(), 0);
        exp_a.delete();
        repeat (3) begin
            @(negedge clk);
            check("t5_idle_after_reset", a_idle, 1);
            check("t5_no_beat_after_reset", a_mvalid, 0);
        end
        @(posedge clk); #1;
        load_frame_a(1'b1, BA);
        dc = done_a; obs_a.delete();
        start_a();
        send_a(FA, 1'b0, stalls);
        wait_idle_a("t5");
        check("t5_beat_count", obs_a.size(), BA);
        check("t5_done_count", done_a - dc, 1);

        // ap_start during RUN is ignored; samples offered in IDLE are refused.
        rand_rdy = 1'b1;
        load_frame_a(1'b1, BA);
        dc = done_a; obs_a.delete();
        start_a();
        fork
            send_a(FA, 1'b1, stalls);
            begin
                repeat (300) @(posedge clk);
                #1;
                a_start = 1'b1;
                @(posedge clk); #1;
                a_start = 1'b0;
                @(negedge clk);
                check("t6_midframe_start_ignored", a_idle, 0);
            end
        join
        wait_idle_a("t6");
        check("t6_beat_count", obs_a.size(), BA);
        check("t6_done_count", done_a - dc, 1);
        a_svalid = 1'b1;
        a_sdata  = 8'hEE;
        repeat (4) begin
            @(negedge clk);
            check("t6_idle_s_tready", a_sready, 0);
            check("t6_idle_held", a_idle, 1);
            @(posedge clk); #1;
        end
        a_svalid = 1'b0;
        load_frame_a(1'b1, BA);
        dc = done_a; obs_a.delete();
        start_a();
        send_a(FA, 1'b0, stalls);
        wait_idle_a("t6b");
        check("t6b_beat_count", obs_a.size(), BA);
        check("t6b_done_count", done_a - dc, 1);
        rand_rdy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_packer_mono8.md
Name: pixel_packer_mono8

Overview:
Return-path counterpart of the Mono8 sequentializer. It takes a byte-wide pixel/prediction stream, such as CNN output or a cropped image, and packs it into 256-bit AXI-Stream beats for the frame-grabber DMA. It frames each result with tlast/tkeep and pads the final partial beat. It sits between the inference core output and the host-bound 256-bit stream.

Parameters:
PIXEL_BIT_WIDTH, 8, width of one input sample
DATA_WIDTH, 256, output beat width; must be an integer multiple of PIXEL_BIT_WIDTH
FRAME_PIXELS, 2304, samples per frame (48x48 default); must be >= 1
PAD_VALUE, 0, byte value written into unused lanes of the final beat

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
ap_start  in  1  arm packer for one frame; sampled only in IDLE
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse when the tlast beat handshakes
s_axis_tvalid  in  1  input sample valid
s_axis_tready  out  1  input sample ready
s_axis_tdata  in  PIXEL_BIT_WIDTH  input sample
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output beat ready
m_axis_tdata  out  DATA_WIDTH  packed beat
m_axis_tkeep  out  DATA_WIDTH/8  byte enables
m_axis_tlast  out  1  last beat of frame

Behaviour:
- Derived constants: LANES = DATA_WIDTH/PIXEL_BIT_WIDTH (32). BEATS = ceil(FRAME_PIXELS/LANES). TAIL = FRAME_PIXELS mod LANES (0 means full).
- Lane order: the k-th accepted sample of a beat goes to tdata[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH]. Lane 0 holds the earliest sample, so the layout is the exact inverse of the sequentializer.
- Reset values: ap_idle=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0. All counters are 0 and the state is IDLE.
- FSM states:
  - IDLE: ap_start=1 clears counters and moves to RUN on the next cycle. ap_start is ignored in any other state.
  - RUN: accepts samples. After the FRAME_PIXELS-th sample handshakes, moves to FLUSH. s_axis_tready is 0 from that point.
  - FLUSH: waits for the tlast beat to handshake, pulses ap_done that same cycle, then returns to IDLE.
- Datapath:
  - Accumulator: a DATA_WIDTH shift/lane register plus a lane counter (0..LANES-1).
  - Output register: one registered beat acting as a skid/holding stage.
- Transfer to the output register:
  - A beat moves from the accumulator to the output register when the accumulator is complete, meaning all LANES samples are in or the frame's last sample is in.
  - The output register must be empty or handshaking in the same cycle.
- s_axis_tready = (state==RUN) and not (accumulator complete and output register occupied and not m_axis_tready). This sustains 1 sample/cycle with m_axis_tready held high.
- Latency: the first output beat is valid 1 cycle after its LANES-th sample handshakes.
- Final beat:
  - If TAIL≠0, lanes TAIL..LANES-1 carry PAD_VALUE and their tkeep bits are 0. tkeep = (1<<(TAIL*PIXEL_BIT_WIDTH/8))-1.
  - All other beats have tkeep all-ones and tlast=0.
  - The tlast beat has tlast=1.
- Output stability: m_axis_tdata, tkeep and tlast stay constant while m_axis_tvalid=1 and m_axis_tready=0. m_axis_tvalid never deasserts without a handshake.
- Simultaneous events: output handshake and transfer of a new beat in the same cycle must lose no data. Input sample handshake and lane-counter wrap in the same cycle must lose no data.
- Input backpressure: s_axis_tvalid low mid-frame simply stalls. No timeout.
- Reset mid-frame: everything is discarded immediately and no partial beat is emitted. After reset release, the block waits for a fresh ap_start.

Decomposition:
- Package pixel_packer_pkg: state_t enum (IDLE, RUN, FLUSH), localparams LANES, BEATS, TAIL, KEEP_TAIL.
- One natural sub-module: axis_beat_reg, a single-entry output holding register with valid/ready, tdata/tkeep/tlast.

Test Plan:
1. Defaults (FRAME_PIXELS=2304), samples 0..255 repeating, m_axis_tready=1 -> 72 beats.
   - beat0 tdata[7:0]=0x00, tdata[255:248]=0x1F.
   - tkeep=all-ones on every beat; tlast only on beat 71.
   - ap_done pulses exactly once, in the same cycle as beat 71's handshake.
2. FRAME_PIXELS=40, PAD_VALUE=0xAA, samples 1..40 -> 2 beats.
   - beat1 lanes0..7 = 0x21..0x28, lanes8..31 = 0xAA.
   - tkeep=0x000000FF, tlast=1.
3. Random m_axis_tready (50%) plus random s_axis_tvalid gaps -> output byte sequence identical to test 1; tdata/tkeep/tlast stable during stalls.
4. Sustained throughput: tvalid=1 and tready=1 throughout -> s_axis_tready never drops during RUN; frame completes in 2304 + small constant cycles.
5. Assert reset after 100 samples, release, issue ap_start, send a full frame -> no beats before the new frame; new frame output correct; ap_idle=1 during the reset window.
6. Pulse ap_start during RUN, and send s_axis_tvalid while IDLE:
   - the mid-frame ap_start is ignored;
   - no samples are accepted while IDLE (s_axis_tready=0);
   - the next frame starts only after ap_done.
